// File: rtl/cic_dec_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_ctrl_pkg : shared types, sizes and legal-D check for the CIC    |
// | decimator controller.                                              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cic_ctrl_pkg;

  localparam int DEC_MAX = 16;
  localparam int DEC_W   = $clog2(DEC_MAX + 1);
  localparam int PHASE_W = $clog2(DEC_MAX);

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // Only power-of-two factors up to DEC_MAX are supported by the datapath.
  function automatic logic is_legal_dec(input logic [DEC_W-1:0] d);
    case (d)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_dec_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_dec_ctrl_if : config, datapath and output handshake signals.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface cic_dec_ctrl_if #(
  parameter int DW = 28
);
  import cic_ctrl_pkg::*;

  logic              in_valid;
  logic              cfg_req;
  logic [DEC_W-1:0]  cfg_dec;
  logic              cfg_ack;
  logic              cfg_err;
  logic [DEC_W-1:0]  cic_dec;
  logic [DW-1:0]     cic_y;
  logic              dec_stb;
  logic              busy;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              ovr;
  logic              ovr_clr;

  modport master (
    output in_valid, cfg_req, cfg_dec, cic_y, out_ready, ovr_clr,
    input  cfg_ack, cfg_err, cic_dec, dec_stb, busy, out_data, out_valid, ovr
  );

  modport slave (
    input  in_valid, cfg_req, cfg_dec, cic_y, out_ready, ovr_clr,
    output cfg_ack, cfg_err, cic_dec, dec_stb, busy, out_data, out_valid, ovr
  );

endinterface
`default_nettype wire

// File: rtl/cic_dec_ctrl_strobe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_dec_strobe : input-phase counter and decimated-rate strobe.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cic_dec_strobe
  import cic_ctrl_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              in_valid,
  input  wire logic [DEC_W-1:0]  cic_dec,
  input  wire logic              clear,
  output logic                   dec_stb
);

  logic [PHASE_W-1:0] r_phase;
  logic               r_stb;
  logic               w_last;

  assign w_last  = ({1'b0, r_phase} == (cic_dec - DEC_W'(1)));
  assign dec_stb = r_stb;

  // clear beats in_valid so the sample seen on a reconfiguration edge is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_stb   <= 1'b0;
    end else if (clear) begin
      r_phase <= '0;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= in_valid && w_last;
      if (in_valid) begin
        r_phase <= w_last ? '0 : r_phase + PHASE_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cic_dec_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_dec_ctrl : CIC decimation-factor control, settling and output  |
// | sample holding with overrun detection.                             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cic_dec_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int DW             = 28,
  parameter int SETTLE_OUTPUTS = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  cic_dec_ctrl_if.slave bus
);

  localparam int c_settle_w = (SETTLE_OUTPUTS < 1) ? 1 : $clog2(SETTLE_OUTPUTS + 1);
  localparam logic [c_settle_w-1:0] c_settle_init = c_settle_w'(SETTLE_OUTPUTS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_settle_w-1:0] w_settle_nxt;
  logic [DEC_W-1:0]      r_cic_dec;
  logic                  r_cfg_ack;
  logic                  r_cfg_err;
  logic [DW-1:0]         r_out_data;
  logic                  r_out_valid;
  logic                  r_ovr;

  logic w_accept;
  logic w_legal;
  logic w_reconf;
  logic w_dec_stb;
  logic w_capture;

  // the ack cycle itself blocks acceptance, so a held request repeats every other cycle
  assign w_accept  = bus.cfg_req && !r_cfg_ack;
  assign w_legal   = is_legal_dec(bus.cfg_dec);
  assign w_reconf  = w_accept && w_legal;
  assign w_capture = w_dec_stb && (r_state == ST_RUN);

  cic_dec_strobe u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .cic_dec  (r_cic_dec),
    .clear    (w_reconf),
    .dec_stb  (w_dec_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SETTLE;
      r_settle_cnt <= c_settle_init;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    if (w_reconf) begin
      w_state_nxt  = ST_SETTLE;
      w_settle_nxt = c_settle_init;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (w_dec_stb) begin
            if (r_settle_cnt <= c_settle_w'(1)) begin
              w_state_nxt  = ST_RUN;
              w_settle_nxt = '0;
            end else begin
              w_settle_nxt = r_settle_cnt - c_settle_w'(1);
            end
          end
        end
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_ack <= 1'b0;
      r_cfg_err <= 1'b0;
      r_cic_dec <= DEC_W'(1);
    end else begin
      r_cfg_ack <= w_accept;
      r_cfg_err <= w_accept && !w_legal;
      if (w_reconf) begin
        r_cic_dec <= bus.cfg_dec;
      end
    end
  end

  // newest sample always wins; overrun only when the held one was never taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_data  <= bus.cic_y;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_capture && r_out_valid && !bus.out_ready) begin
        r_ovr <= 1'b1;
      end else if (bus.ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign bus.cfg_ack   = r_cfg_ack;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.cic_dec   = r_cic_dec;
  assign bus.dec_stb   = w_dec_stb;
  assign bus.busy      = (r_state == ST_SETTLE);
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_cic_dec_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cic_dec_ctrl : directed self-checking bench for cic_dec_ctrl.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cic_dec_ctrl;

  localparam int DW = 28;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  cic_dec_ctrl_if #(.DW(DW)) bus ();

  cic_dec_ctrl #(.DW(DW), .SETTLE_OUTPUTS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  64'(bus.busy),      64'd1);
    check({tag, "_dec"},   64'(bus.cic_dec),   64'd1);
    check({tag, "_stb"},   64'(bus.dec_stb),   64'd0);
    check({tag, "_ack"},   64'(bus.cfg_ack),   64'd0);
    check({tag, "_err"},   64'(bus.cfg_err),   64'd0);
    check({tag, "_ov"},    64'(bus.out_valid), 64'd0);
    check({tag, "_od"},    64'(bus.out_data),  64'd0);
    check({tag, "_ovr"},   64'(bus.ovr),       64'd0);
  endtask

  initial begin
    n_chk         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.cfg_req   = 1'b0;
    bus.cfg_dec   = 5'd0;
    bus.cic_y     = '0;
    bus.out_ready = 1'b1;
    bus.ovr_clr   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // D=1 from reset: four strobes discarded, then continuous capture
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.cic_y    = 28'd100;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("d1_stb%0d", k),  64'(bus.dec_stb),   64'd1);
      check($sformatf("d1_busy%0d", k), 64'(bus.busy),      64'(k < 5));
      check($sformatf("d1_ov%0d", k),   64'(bus.out_valid), 64'(k >= 6));
      if (k >= 6) check($sformatf("d1_od%0d", k), 64'(bus.out_data), 64'(100 + k - 1));
      check($sformatf("d1_ovr%0d", k),  64'(bus.ovr),       64'd0);
      bus.cic_y = DW'(100 + k);
    end

    // illegal factor rejected, nothing changes
    bus.cfg_req = 1'b1;
    bus.cfg_dec = 5'd5;
    @(negedge clk);
    check("ill_ack",  64'(bus.cfg_ack), 64'd1);
    check("ill_err",  64'(bus.cfg_err), 64'd1);
    check("ill_dec",  64'(bus.cic_dec), 64'd1);
    check("ill_busy", 64'(bus.busy),    64'd0);
    check("ill_stb",  64'(bus.dec_stb), 64'd1);
    bus.cfg_req = 1'b0;
    @(negedge clk);
    check("ill_ack_drop", 64'(bus.cfg_ack), 64'd0);
    check("ill_stb2",     64'(bus.dec_stb), 64'd1);

    // D=8: strobes every 8 cycles, four discarded, fifth captured
    bus.cfg_req = 1'b1;
    bus.cfg_dec = 5'd8;
    for (int j = 0; j <= 48; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("d8_ack", 64'(bus.cfg_ack), 64'd1);
        check("d8_err", 64'(bus.cfg_err), 64'd0);
        check("d8_dec", 64'(bus.cic_dec), 64'd8);
        bus.cfg_req = 1'b0;
      end
      check($sformatf("d8_stb%0d", j), 64'(bus.dec_stb), 64'(j > 0 && j % 8 == 0));
      if (j <= 41) begin
        check($sformatf("d8_busy%0d", j), 64'(bus.busy),      64'(j <= 32));
        check($sformatf("d8_ov%0d", j),   64'(bus.out_valid), 64'(j == 0 || j == 41));
      end
      if (j == 41) check("d8_od", 64'(bus.out_data), 64'd1040);
      bus.cic_y = DW'(1000 + j);
    end

    // legal D=16 on a RUN strobe cycle: sample kept, then settle, phase restarts
    bus.cfg_req   = 1'b1;
    bus.cfg_dec   = 5'd16;
    bus.cic_y     = 28'h0ABCDE;
    bus.out_ready = 1'b0;
    for (int m = 0; m <= 16; m++) begin
      @(negedge clk);
      if (m == 0) begin
        check("d16_ack", 64'(bus.cfg_ack), 64'd1);
        check("d16_err", 64'(bus.cfg_err), 64'd0);
        check("d16_dec", 64'(bus.cic_dec), 64'd16);
        check("d16_ovr", 64'(bus.ovr),     64'd0);
        bus.cfg_req = 1'b0;
        bus.cic_y   = 28'h0000111;
      end
      check($sformatf("d16_stb%0d", m),  64'(bus.dec_stb),   64'(m == 16));
      check($sformatf("d16_busy%0d", m), 64'(bus.busy),      64'd1);
      check($sformatf("d16_ov%0d", m),   64'(bus.out_valid), 64'd1);
      check($sformatf("d16_od%0d", m),   64'(bus.out_data),  64'h0ABCDE);
    end

    // asynchronous reset in SETTLE with D=16
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    bus.in_valid = 1'b0;
    @(negedge clk);

    // D=2 with consumer stalled: overrun, newest wins, set beats clear
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.cfg_req  = 1'b1;
    bus.cfg_dec  = 5'd2;
    bus.cic_y    = DW'(1999);
    for (int j = 0; j <= 18; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("d2_ack", 64'(bus.cfg_ack), 64'd1);
        check("d2_err", 64'(bus.cfg_err), 64'd0);
        check("d2_dec", 64'(bus.cic_dec), 64'd2);
        bus.cfg_req = 1'b0;
      end
      check($sformatf("d2_stb%0d", j),  64'(bus.dec_stb),   64'(j > 0 && j % 2 == 0));
      check($sformatf("d2_busy%0d", j), 64'(bus.busy),      64'(j <= 8));
      check($sformatf("d2_ov%0d", j),   64'(bus.out_valid), 64'(j >= 11 && j != 18));
      check($sformatf("d2_ovr%0d", j),  64'(bus.ovr),       64'(j >= 13 && j != 16));
      if (j >= 11) check($sformatf("d2_od%0d", j), 64'(bus.out_data), 64'(2000 + ((j - 1) / 2) * 2));
      bus.cic_y     = DW'(2000 + j);
      bus.ovr_clr   = (j == 14 || j == 15);
      bus.out_ready = (j == 17);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_dec_ctrl.md
CIC_DEC_CTRL -- requirements
Module: cic_dec_ctrl

Interface
REQ-001 Parameter DW, default 28, width of decimator output data (16 input + 12 growth).
REQ-002 Parameter SETTLE_OUTPUTS, default 4, decimated outputs discarded after every reconfiguration or reset.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  one input sample presented to the CIC datapath this cycle.
REQ-006 cfg_req  input  1  request to change decimation factor.
REQ-007 cfg_dec  input  5  requested decimation factor D.
REQ-008 cfg_ack  output  1  one-cycle acknowledge of an accepted request.
REQ-009 cfg_err  output  1  qualifies cfg_ack; 1 = request rejected.
REQ-010 cic_dec  output  5  active decimation factor driven to the datapath.
REQ-011 cic_y  input  DW  decimator datapath output.
REQ-012 dec_stb  output  1  decimated-rate strobe; cic_y is sampled in this cycle.
REQ-013 busy  output  1  high while in SETTLE.
REQ-014 out_data  output  DW  held output sample.
REQ-015 out_valid  output  1  out_data holds an unconsumed sample.
REQ-016 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-017 ovr  output  1  sticky overrun flag.
REQ-018 ovr_clr  input  1  clears ovr.

Function
REQ-019 Legal D SHALL be {1,2,4,8,16}; any other cfg_dec value is illegal.
REQ-020 A request SHALL be accepted in any cycle with cfg_req=1 and cfg_ack=0; cfg_ack pulses high for exactly the next cycle.
REQ-021 Illegal request: cfg_ack=1 with cfg_err=1; cic_dec, counter, state unchanged.
REQ-022 Legal request: cfg_ack=1, cfg_err=0; cic_dec loads cfg_dec, phase counter clears to 0, state goes SETTLE, settle counter loads SETTLE_OUTPUTS, all on the same edge.
REQ-023 cfg_req held high SHALL be re-accepted every second cycle; requester drops cfg_req on cfg_ack.
REQ-024 Phase counter (4 bits) SHALL advance only on in_valid; when in_valid=1 and count=cic_dec-1 it wraps to 0 and dec_stb=1 in the next cycle, otherwise dec_stb=0.
REQ-025 D=1: dec_stb SHALL follow in_valid delayed one cycle, counter stays 0.
REQ-026 in_valid in the same cycle as a legal request acceptance SHALL not be counted.
REQ-027 States: SETTLE, RUN. SETTLE: each dec_stb discards cic_y and decrements settle counter; the dec_stb that brings it to 0 moves state to RUN (that sample is also discarded).
REQ-028 RUN: dec_stb SHALL load cic_y into out_data and set out_valid on the next edge; latency last-input-of-group -> out_valid = 2 cycles.
REQ-029 Capture with out_valid=1 and out_ready=0: out_data overwritten (newest wins), out_valid stays 1, ovr set.
REQ-030 Capture with out_valid=1 and out_ready=1: new sample loaded, out_valid stays 1, no overrun.
REQ-031 out_ready=1 without capture SHALL clear out_valid.
REQ-032 ovr_clr and a new overrun in the same cycle: set wins.
REQ-033 Legal request accepted on a RUN dec_stb cycle: that sample IS captured (old D), then SETTLE; pending out_valid/out_data retained across reconfiguration.
REQ-034 busy SHALL equal (state==SETTLE) combinationally from the state register.

Reset
REQ-035 On rst_n=0: state SETTLE, settle counter SETTLE_OUTPUTS, cic_dec=1, counter 0, dec_stb=0, cfg_ack=0, cfg_err=0, out_valid=0, out_data=0, ovr=0.
REQ-036 Reset mid-reconfiguration or mid-settle SHALL abandon it entirely; no cfg_ack is issued after reset release for a pre-reset request.

Structure
REQ-037 Package cic_ctrl_pkg SHALL hold the state enum, DEC_MAX=16, and the legal-D check function.
REQ-038 Sub-module cic_dec_strobe SHALL contain the phase counter and dec_stb generation (inputs: in_valid, cic_dec, clear).

Verification
REQ-039 Reset release, D=1, in_valid continuous -> first 4 strobes discarded, busy falls after 4th, out_valid from 6th cycle onward.
REQ-040 cfg_dec=8 legal, in_valid continuous -> cfg_ack=1/cfg_err=0, dec_stb every 8 cycles, 4 discarded, 5th captured.
REQ-041 cfg_dec=5 -> cfg_ack=1, cfg_err=1, cic_dec unchanged, strobe period unchanged.
REQ-042 RUN D=2, out_ready=0 -> second capture sets ovr, out_data = latest cic_y; ovr_clr same cycle as next overrun -> ovr stays 1.
REQ-043 Legal cfg_dec=16 on a dec_stb cycle -> sample captured, then busy=1, counter restarts from 0.
REQ-044 rst_n asserted during SETTLE with cic_dec=16 -> all outputs at reset values, cic_dec=1.
